// File: rtl/uart_rx_frame.sv
// UART receiver (8N1, LSB first) that collects eight bytes, MSB byte first, into one
// 64-bit word, with stop-bit checking and an inter-byte timeout that drops partial words.
module uart_rx_frame #(
    parameter logic [19:0] UART_BPS     = 20'd256000,
    parameter logic [25:0] CLK_FREQ     = 26'd50_000_000,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        rx,
    output logic [63:0] po_data,
    output logic        po_flag,
    output logic [7:0]  byte_data,
    output logic        byte_flag,
    output logic        frame_err
);

    localparam int unsigned BAUD_CNT_MAX = 32'(CLK_FREQ / UART_BPS);
    localparam int unsigned SAMPLE_PT    = BAUD_CNT_MAX / 2;
    localparam int unsigned IDLE_MAX     = TIMEOUT_BITS * BAUD_CNT_MAX;
    localparam int unsigned BW           = $clog2(BAUD_CNT_MAX);
    localparam int unsigned IW           = $clog2(IDLE_MAX);

    localparam logic [BW-1:0] SAMPLE_V  = BW'(SAMPLE_PT);
    localparam logic [BW-1:0] LAST_V    = BW'(BAUD_CNT_MAX - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_MAX - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e         state_q, state_d;
    logic           rx_meta_q, rx_s_q, rx_prev_q;
    logic [BW-1:0]  baud_cnt_q, baud_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [55:0]    frame_sh_q, frame_sh_d;
    logic [2:0]     byte_cnt_q, byte_cnt_d;
    logic [IW-1:0]  idle_cnt_q, idle_cnt_d;
    logic [63:0]    po_data_q, po_data_d;
    logic           po_flag_q, po_flag_d;
    logic [7:0]     byte_data_q, byte_data_d;
    logic           byte_flag_q, byte_flag_d;
    logic           frame_err_q, frame_err_d;

    logic rx_fall, at_sample, at_last, timeout;

    assign rx_fall   = rx_prev_q & ~rx_s_q;
    assign at_sample = (baud_cnt_q == SAMPLE_V);
    assign at_last   = (baud_cnt_q == LAST_V);
    assign timeout   = (state_q == IDLE) && (byte_cnt_q != 3'd0) && (idle_cnt_q == IDLE_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // STOP returns to IDLE at its sample point so a back-to-back start edge is not missed
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (rx_fall) state_d = START;
            START: begin
                if (at_sample && rx_s_q) state_d = IDLE;
                else if (at_last)        state_d = DATA;
            end
            DATA:  if (at_last && bit_cnt_q == 3'd7) state_d = STOP;
            STOP:  if (at_sample) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        frame_sh_d  = frame_sh_q;
        byte_cnt_d  = byte_cnt_q;
        idle_cnt_d  = '0;
        po_data_d   = po_data_q;
        po_flag_d   = 1'b0;
        byte_data_d = byte_data_q;
        byte_flag_d = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == IDLE || state_d == IDLE) baud_cnt_d = '0;
        else if (at_last)                       baud_cnt_d = '0;
        else                                    baud_cnt_d = baud_cnt_q + BW'(1);

        if (state_q == START && at_last) bit_cnt_d = '0;
        if (state_q == DATA && at_last)  bit_cnt_d = bit_cnt_q + 3'd1;
        if (state_q == DATA && at_sample) shreg_d = {rx_s_q, shreg_q[7:1]};

        if (state_q == STOP && at_sample) begin
            if (rx_s_q) begin
                byte_data_d = shreg_q;
                byte_flag_d = 1'b1;
                frame_sh_d  = {frame_sh_q[47:0], shreg_q};
                if (byte_cnt_q == 3'd7) begin
                    po_data_d  = {frame_sh_q, shreg_q};
                    po_flag_d  = 1'b1;
                    byte_cnt_d = '0;
                end else begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                end
            end else begin
                frame_err_d = 1'b1;
                byte_cnt_d  = '0;
            end
        end

        // Timeout takes priority over a simultaneous start edge; that byte opens a new word
        if (timeout) begin
            byte_cnt_d  = '0;
            frame_err_d = 1'b1;
            idle_cnt_d  = '0;
        end else if (state_q == IDLE && state_d == IDLE && byte_cnt_q != 3'd0) begin
            idle_cnt_d = idle_cnt_q + IW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            frame_sh_q  <= '0;
            byte_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            po_data_q   <= '0;
            po_flag_q   <= 1'b0;
            byte_data_q <= '0;
            byte_flag_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            frame_sh_q  <= frame_sh_d;
            byte_cnt_q  <= byte_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            po_data_q   <= po_data_d;
            po_flag_q   <= po_flag_d;
            byte_data_q <= byte_data_d;
            byte_flag_q <= byte_flag_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign po_data   = po_data_q;
    assign po_flag   = po_flag_q;
    assign byte_data = byte_data_q;
    assign byte_flag = byte_flag_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: random words driven as 8N1 serial bytes, checked against a
// byte/word/error scoreboard built from the framing rules.
module tb_uart_rx_frame;

    localparam int BIT = 50;          // clocks per bit at 1 Mbaud / 50 MHz
    localparam int TMO = 20 * BIT;    // inter-byte timeout in clocks

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [63:0] po_data;
    logic        po_flag;
    logic [7:0]  byte_data;
    logic        byte_flag;
    logic        frame_err;

    uart_rx_frame #(
        .UART_BPS    (20'd1_000_000),
        .CLK_FREQ    (26'd50_000_000),
        .TIMEOUT_BITS(20)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .rx       (rx),
        .po_data  (po_data),
        .po_flag  (po_flag),
        .byte_data(byte_data),
        .byte_flag(byte_flag),
        .frame_err(frame_err)
    );

    always #10 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Observed events
    logic [7:0]  got_bytes[$];
    logic [63:0] got_words[$];
    int          got_errs = 0;
    int          lone_po = 0;

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (byte_flag) got_bytes.push_back(byte_data);
            if (po_flag) begin
                got_words.push_back(po_data);
                if (!byte_flag) lone_po++;
            end
            if (frame_err) got_errs++;
        end
    end

    // Reference model
    logic [7:0]  exp_bytes[$];
    logic [63:0] exp_words[$];
    int          exp_errs = 0;
    logic [63:0] partial = '0;
    int          nbytes = 0;
    logic [63:0] last_word = '0;

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(b[i], BIT);
        drive(stop, BIT);
        if (stop) begin
            exp_bytes.push_back(b);
            partial = {partial[55:0], b};
            nbytes++;
            if (nbytes == 8) begin
                exp_words.push_back(partial);
                last_word = partial;
                nbytes = 0;
            end
        end else begin
            exp_errs++;
            nbytes = 0;
        end
    endtask

    task automatic idle(input int cycles);
        drive(1'b1, cycles);
        if (nbytes != 0 && cycles >= TMO) begin
            exp_errs++;
            nbytes = 0;
        end
    endtask

    task automatic send_word(input logic [63:0] w, input int gap_max);
        for (int i = 0; i < 8; i++) begin
            send_byte(w[63 - 8*i -: 8], 1'b1);
            idle(int'($urandom_range(0, gap_max)));
        end
    endtask

    function automatic logic [63:0] rand64();
        return {32'($urandom), 32'($urandom)};
    endfunction

    task automatic verify(input string tag);
        int nb, nw;
        repeat (5) @(negedge sys_clk);
        check({tag, "/nbytes"}, 64'(got_bytes.size()), 64'(exp_bytes.size()));
        check({tag, "/nwords"}, 64'(got_words.size()), 64'(exp_words.size()));
        nb = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
        nw = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
        for (int i = 0; i < nb; i++) check({tag, "/byte"}, 64'(got_bytes[i]), 64'(exp_bytes[i]));
        for (int i = 0; i < nw; i++) check({tag, "/word"}, got_words[i], exp_words[i]);
        check({tag, "/frame_err"}, 64'(got_errs), 64'(exp_errs));
        check({tag, "/po_data_hold"}, po_data, last_word);
        check({tag, "/po_flag_alone"}, 64'(lone_po), 64'd0);
        got_bytes.delete();
        got_words.delete();
        exp_bytes.delete();
        exp_words.delete();
        got_errs = 0;
        exp_errs = 0;
        lone_po = 0;
    endtask

    initial begin
        logic [63:0] w;

        repeat (3) @(negedge sys_clk);
        check("rst/po_data", po_data, 64'd0);
        check("rst/byte_data", 64'(byte_data), 64'd0);
        check("rst/flags", 64'({po_flag, byte_flag, frame_err}), 64'd0);
        sys_rst_n = 1'b1;
        idle(2 * BIT);

        send_word(64'h0123_4567_89AB_CDEF, 0);
        verify("word1");

        drive(1'b0, 12);
        idle(3 * BIT);
        verify("glitch");
        send_word(rand64(), 0);
        verify("glitch_word");

        w = rand64();
        send_byte(w[63:56], 1'b1);
        send_byte(w[55:48], 1'b1);
        send_byte(8'h55, 1'b0);
        drive(1'b0, 2 * BIT);
        idle(BIT);
        send_word(rand64(), 2 * BIT);
        verify("stop_err");

        w = rand64();
        send_byte(w[63:56], 1'b1);
        send_byte(w[55:48], 1'b1);
        send_byte(w[47:40], 1'b1);
        idle(21 * BIT);
        verify("timeout");
        send_word(64'hFFFF_FFFF_FFFF_FFFE, 0);
        verify("timeout_word");

        w = rand64();
        for (int i = 0; i < 5; i++) send_byte(w[63 - 8*i -: 8], 1'b1);
        drive(1'b0, BIT);
        for (int i = 0; i < 3; i++) drive(w[16 + i], BIT);
        drive(w[19], BIT / 2);
        #3 sys_rst_n = 1'b0;
        #1;
        check("midrst/po_data", po_data, 64'd0);
        check("midrst/byte_data", 64'(byte_data), 64'd0);
        check("midrst/flags", 64'({po_flag, byte_flag, frame_err}), 64'd0);
        nbytes = 0;
        partial = '0;
        last_word = '0;
        rx = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle(2 * BIT);
        send_word(rand64(), 0);
        verify("after_rst");

        send_word(rand64(), 0);
        send_word(rand64(), 0);
        verify("back2back");

        for (int k = 0; k < 3; k++) send_word(rand64(), 5 * BIT);
        verify("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
